// File: rtl/dll_trunc_ctrl_pkg.sv
// Shared definitions for the DLL accumulator truncation controller:
// default widths, truncation index bounds and the FSM state encoding.
package dll_trunc_ctrl_pkg;
  localparam int DEF_ACC_WIDTH   = 19;
  localparam int DEF_OUT_WIDTH   = 11;
  localparam int DEF_INDEX_WIDTH = 5;
  localparam int DEF_WINDOW      = 16;

  // Index bounds for the default widths: [OUT_WIDTH-1, ACC_WIDTH-1]
  localparam int IDX_MIN = DEF_OUT_WIDTH - 1;
  localparam int IDX_MAX = DEF_ACC_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRUNC_E = 2'd1,
    TRUNC_L = 2'd2,
    OUT     = 2'd3
  } state_t;
endpackage

// File: rtl/dll_trunc_ctrl_msb.sv
// Leading-one detector: position of the highest set bit, 0 for a zero input.
module dll_msb_detect
  import dll_trunc_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]   i_acc,
  output logic [INDEX_WIDTH-1:0] o_pos
);
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < ACC_WIDTH; i++)
      if (i_acc[i]) o_pos = INDEX_WIDTH'(i);
  end
endmodule

// File: rtl/dll_trunc_ctrl.sv
// Sequences early/late magnitudes through a shared external truncator and
// adapts the truncation index from the peak leading-one seen per window.
module dll_trunc_ctrl
  import dll_trunc_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int WINDOW      = DEF_WINDOW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dump_valid,
  input  logic [ACC_WIDTH-1:0]   early_acc,
  input  logic [ACC_WIDTH-1:0]   late_acc,
  input  logic                   index_freeze,
  output logic                   ready,
  output logic [INDEX_WIDTH-1:0] trunc_index,
  output logic [ACC_WIDTH-1:0]   trunc_in,
  input  logic [OUT_WIDTH-1:0]   trunc_out,
  output logic [OUT_WIDTH-1:0]   early_out,
  output logic [OUT_WIDTH-1:0]   late_out,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_valid,
  output logic                   overrun
);
  localparam int CW = $clog2(WINDOW);
  localparam logic [INDEX_WIDTH-1:0] IDX_LO = INDEX_WIDTH'(OUT_WIDTH - 1);
  localparam logic [INDEX_WIDTH-1:0] IDX_HI = INDEX_WIDTH'(ACC_WIDTH - 1);

  state_t                 r_state, w_next;
  logic [ACC_WIDTH-1:0]   r_early, r_late, w_max_acc;
  logic [INDEX_WIDTH-1:0] r_cur, r_idx, r_peak, r_oidx, w_msb, w_step, w_new_idx;
  logic [OUT_WIDTH-1:0]   r_eout, r_lout;
  logic [CW-1:0]          r_cnt;
  logic                   r_last, r_overrun;
  logic                   w_accept, w_update;

  assign w_accept  = dump_valid && (r_state == IDLE);
  assign w_update  = (r_state == OUT) && r_last;
  assign w_max_acc = (early_acc >= late_acc) ? early_acc : late_acc;

  dll_msb_detect #(.ACC_WIDTH(ACC_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) u_msb (
    .i_acc (w_max_acc),
    .o_pos (w_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (dump_valid) w_next = TRUNC_E;
      TRUNC_E: w_next = TRUNC_L;
      TRUNC_L: w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // In IDLE the truncator sees the live index so it tracks updates immediately
  always_comb begin
    ready       = 1'b0;
    out_valid   = 1'b0;
    trunc_in    = '0;
    trunc_index = r_idx;
    case (r_state)
      IDLE: begin
        ready       = 1'b1;
        trunc_index = r_cur;
      end
      TRUNC_E: trunc_in  = r_early;
      TRUNC_L: trunc_in  = r_late;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_step = r_cur;
    if (r_peak > r_cur)      w_step = r_peak;
    else if (r_peak < r_cur) w_step = r_cur - 1'b1;
    w_new_idx = w_step;
    if (w_step < IDX_LO)      w_new_idx = IDX_LO;
    else if (w_step > IDX_HI) w_new_idx = IDX_HI;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_early   <= '0;
      r_late    <= '0;
      r_cur     <= IDX_HI;
      r_idx     <= IDX_HI;
      r_peak    <= '0;
      r_oidx    <= IDX_HI;
      r_eout    <= '0;
      r_lout    <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_early <= early_acc;
        r_late  <= late_acc;
        r_idx   <= r_cur;
        r_cnt   <= r_cnt + 1'b1;
        r_last  <= (r_cnt == CW'(WINDOW - 1));
        if (w_msb > r_peak) r_peak <= w_msb;
      end
      if (dump_valid && (r_state != IDLE)) r_overrun <= 1'b1;
      if (r_state == TRUNC_E) begin
        r_eout <= trunc_out;
        r_oidx <= r_idx;
      end
      if (r_state == TRUNC_L) r_lout <= trunc_out;
      // No dump can be accepted in OUT, so this never collides with the peak update above
      if (w_update) begin
        r_peak <= '0;
        if (!index_freeze) r_cur <= w_new_idx;
      end
    end
  end

  assign early_out = r_eout;
  assign late_out  = r_lout;
  assign out_index = r_oidx;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_dll_trunc_ctrl.sv
// Scoreboard bench for dll_trunc_ctrl with a behavioural saturating truncator.
module tb_dll_trunc_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dump_valid = 1'b0;
  logic        index_freeze = 1'b0;
  logic [18:0] early_acc = '0, late_acc = '0;
  logic        ready, out_valid, overrun;
  logic [4:0]  trunc_index, out_index;
  logic [18:0] trunc_in;
  logic [10:0] trunc_out, early_out, late_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Truncator: 11-bit window ending at bit idx, saturated to the positive signed max
  function automatic logic [10:0] trunc_f(input logic [18:0] v, input logic [4:0] idx);
    logic [18:0] s;
    s = v >> (idx - 5'd10);
    if (s > 19'h3FF) return 11'h3FF;
    return s[10:0];
  endfunction

  assign trunc_out = trunc_f(trunc_in, trunc_index);

  dll_trunc_ctrl dut (
    .clk(clk), .reset(reset), .dump_valid(dump_valid),
    .early_acc(early_acc), .late_acc(late_acc), .index_freeze(index_freeze),
    .ready(ready), .trunc_index(trunc_index), .trunc_in(trunc_in),
    .trunc_out(trunc_out), .early_out(early_out), .late_out(late_out),
    .out_index(out_index), .out_valid(out_valid), .overrun(overrun)
  );

  typedef struct {
    logic [10:0] e;
    logic [10:0] l;
    logic [4:0]  idx;
    int          c;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t mx;
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mx = sb.pop_front();
        chk("early_out", early_out, mx.e);
        chk("late_out", late_out, mx.l);
        chk("out_index", out_index, mx.idx);
        chk("latency", cyc - mx.c, 3);
      end
    end
  end

  // One dump, expected result pushed at issue; returns at the start of the OUT cycle
  task automatic send(input logic [18:0] e, input logic [18:0] l, input logic [4:0] idx);
    exp_t x;
    @(posedge clk); #1;
    dump_valid = 1'b1; early_acc = e; late_acc = l;
    x.e = trunc_f(e, idx); x.l = trunc_f(l, idx); x.idx = idx; x.c = cyc;
    sb.push_back(x);
    @(posedge clk); #1;
    dump_valid = 1'b0; early_acc = '0; late_acc = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_trunc_index", trunc_index, 18);
    chk("rst_trunc_in", trunc_in, 0);
    chk("rst_early_out", early_out, 0);
    chk("rst_late_out", late_out, 0);
    chk("rst_out_index", out_index, 18);
    chk("rst_overrun", overrun, 0);
  endtask

  task automatic idle_idx(input logic [4:0] exp);
    @(posedge clk); @(negedge clk);
    chk("idle_ready", ready, 1);
    chk("idle_trunc_index", trunc_index, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state();

    // dump coincident with reset is ignored
    @(posedge clk); #1;
    reset = 1'b1; dump_valid = 1'b1; early_acc = 19'h7FFFF;
    @(posedge clk); #1;
    reset = 1'b0; dump_valid = 1'b0; early_acc = '0;
    @(negedge clk);
    chk("coinc_ready", ready, 1);
    chk("coinc_overrun", overrun, 0);
    repeat (4) @(posedge clk);

    send(19'h7FFFF, 19'h0, 5'd18);

    // downward stepping: one index per window of msb-10 dumps, then hold at 10
    do_reset();
    for (int w = 0; w < 9; w++)
      for (int k = 0; k < 16; k++)
        send(19'h00400, 19'h0, 5'(18 - w));
    idle_idx(5'd10);
    send(19'h00123, 19'h0, 5'd10);
    send(19'h0, 19'h20000, 5'd10);
    for (int k = 0; k < 14; k++) send(19'h00400, 19'h0, 5'd10);
    idle_idx(5'd17);
    send(19'h00400, 19'h0, 5'd17);

    // back-to-back dump: second dropped, overrun sticky
    do_reset();
    @(posedge clk); #1;
    dump_valid = 1'b1; early_acc = 19'h00400;
    mx.e = trunc_f(19'h00400, 5'd18); mx.l = 11'h0; mx.idx = 5'd18; mx.c = cyc;
    sb.push_back(mx);
    @(posedge clk); #1;
    early_acc = 19'h7FFFF;
    @(posedge clk); #1;
    dump_valid = 1'b0; early_acc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("overrun_sticky", overrun, 1);

    // reset in TRUNC_L aborts the in-flight dump
    @(posedge clk); #1;
    dump_valid = 1'b1; early_acc = 19'h7FFFF; late_acc = 19'h12345;
    @(posedge clk); #1;
    dump_valid = 1'b0; early_acc = '0; late_acc = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state();
    repeat (5) @(posedge clk);

    // frozen window end keeps the index but still wraps counter and peak
    index_freeze = 1'b1;
    for (int k = 0; k < 16; k++) send(19'h00400, 19'h0, 5'd18);
    idle_idx(5'd18);
    index_freeze = 1'b0;
    for (int k = 0; k < 16; k++) send(19'h00400, 19'h0, 5'd18);
    idle_idx(5'd17);

    repeat (6) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
